// File: rtl/vdp2_vram_write_drain_pkg.sv
// vdp2_vram_write_drain_pkg: shared widths, write-FIFO field layout and FSM state codes
package vdp2_vram_write_drain_pkg;
  localparam int WFIFO_W = 36;
  localparam int WF_BE_HI = 35;
  localparam int WF_BE_LO = 34;
  localparam int WF_A_HI = 33;
  localparam int WF_A_LO = 16;
  localparam int WF_D_HI = 15;
  localparam int WF_D_LO = 0;
  localparam int BANK_BIT = 17;
  localparam logic [7:0] TIMEOUT = 8'd255;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  typedef struct packed {
    logic [WF_BE_HI-WF_BE_LO:0] be;
    logic [WF_A_HI-WF_A_LO:0] addr;
    logic [WF_D_HI-WF_D_LO:0] d;
  } wentry_t;
endpackage

// File: rtl/vdp2_vram_write_drain_if.sv
// vdp2_vram_write_drain_if: write-FIFO head, slot grants and both VRAM bank write ports
interface vdp2_vram_write_drain_if;
  import vdp2_vram_write_drain_pkg::*;
  logic [WFIFO_W-1:0] fifo_q;
  logic fifo_empty, fifo_rdreq;
  logic slot_a, slot_b;
  logic [16:0] va_addr, vb_addr;
  logic [15:0] va_d, vb_d;
  logic [1:0] va_be, vb_be;
  logic va_we, vb_we, va_rdy, vb_rdy;
  logic busy, err;
  modport master (
    input fifo_q, fifo_empty, slot_a, slot_b, va_rdy, vb_rdy,
    output fifo_rdreq, va_addr, vb_addr, va_d, vb_d, va_be, vb_be, va_we, vb_we, busy, err
  );
  modport slave (
    output fifo_q, fifo_empty, slot_a, slot_b, va_rdy, vb_rdy,
    input fifo_rdreq, va_addr, vb_addr, va_d, vb_d, va_be, vb_be, va_we, vb_we, busy, err
  );
endinterface

// File: rtl/vdp2_vram_write_drain.sv
// vdp2_vram_write_drain: drains queued CPU VRAM writes to bank A/B inside granted access slots
module vdp2_vram_write_drain
  import vdp2_vram_write_drain_pkg::*;
(
  input logic clk,
  input logic rst_n,
  vdp2_vram_write_drain_if.master bus
);
  logic [1:0] state_q, state_d;
  wentry_t hold_q, hold_d, head;
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic sel, pending, timeout, done, capture;
  logic [1:0] slot, rdy, b_we;
  logic [16:0] b_addr [2];
  logic [15:0] b_d [2];
  logic [1:0] b_be [2];
  assign head = wentry_t'(bus.fifo_q);
  assign sel = hold_q.addr[BANK_BIT];
  assign slot = {bus.slot_b, bus.slot_a};
  assign rdy = {bus.vb_rdy, bus.va_rdy};
  always_comb begin
    pending = state_q != S_IDLE;
    timeout = pending && cnt_q == TIMEOUT;
    done = state_q == S_WRITE && rdy[sel];
    capture = rst_n && !bus.fifo_empty && (state_q == S_IDLE || done);
    state_d = state_q;
    hold_d = hold_q;
    cnt_d = pending ? cnt_q + 8'd1 : cnt_q;
    err_d = err_q;
    // completion beats timeout; a zero-BE entry is popped but never written
    if (capture) begin
      hold_d = head;
      cnt_d = '0;
      state_d = head.be == 2'b00 ? S_IDLE : S_WAIT;
    end else if (done) begin
      state_d = S_IDLE;
    end else if (timeout) begin
      state_d = S_IDLE;
      err_d = 1'b1;
    end else if (state_q == S_WAIT && slot[sel]) begin
      state_d = S_WRITE;
    end
  end
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      b_we[i] = state_q == S_WRITE && sel == i[0];
      b_addr[i] = sel == i[0] ? hold_q.addr[16:0] : '0;
      b_d[i] = sel == i[0] ? hold_q.d : '0;
      b_be[i] = sel == i[0] ? hold_q.be : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.fifo_rdreq = capture;
  assign bus.busy = pending || !bus.fifo_empty;
  assign bus.err = err_q;
  assign bus.va_we = b_we[0];
  assign bus.vb_we = b_we[1];
  assign bus.va_addr = b_addr[0];
  assign bus.vb_addr = b_addr[1];
  assign bus.va_d = b_d[0];
  assign bus.vb_d = b_d[1];
  assign bus.va_be = b_be[0];
  assign bus.vb_be = b_be[1];
endmodule
